// File: rtl/usb_fx3_pkg.sv
// Shared definitions for the FX3 slave-FIFO read path into the cache RAM.
// Holds the state codes exported on usb_rd_state, the socket constant and parameter defaults.
package usb_fx3_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_FLAG = 4'd1,
        ST_SELECT    = 4'd2,
        ST_OE_ON     = 4'd3,
        ST_PAUSE     = 4'd4,
        ST_STREAM    = 4'd6,
        ST_DRAIN     = 4'd7,
        ST_DONE      = 4'd8
    } rd_state_e;

    localparam logic [1:0] FX3_RD_SOCKET  = 2'b11;
    localparam int         ADDR_W_DEF     = 8;
    localparam int         BURST_LEN_DEF  = 256;
    localparam int         RD_LATENCY_DEF = 2;

endpackage

// File: rtl/usb_cache_fill_ctrl_if.sv
// FX3 slave-FIFO read strobes plus the cache RAM write port, as seen by the fill controller.
interface usb_cache_fill_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              usb_flaga;
    logic              usb_slcs_n;
    logic              usb_sloe_n;
    logic              usb_slrd_n;
    logic [1:0]        usb_fifoaddr;
    logic              cache_wren;
    logic [ADDR_W-1:0] cache_wraddress;

    modport master (
        input  usb_flaga,
        output usb_slcs_n, usb_sloe_n, usb_slrd_n, usb_fifoaddr,
        output cache_wren, cache_wraddress
    );

    modport slave (
        output usb_flaga,
        input  usb_slcs_n, usb_sloe_n, usb_slrd_n, usb_fifoaddr,
        input  cache_wren, cache_wraddress
    );
endinterface

// File: rtl/fx3_rd_pipe.sv
// Delays the FX3 read strobe by the bus read latency so the cache write enable lines up with
// valid data; the last stage is the registered cache write enable.
module fx3_rd_pipe #(
    parameter int RD_LATENCY = 2
) (
    input  logic wrclock,
    input  logic rst_n,
    input  logic strobe_i,
    output logic wren_o
);

    logic [RD_LATENCY-1:0] pipe_q;

    always_ff @(posedge wrclock or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            // Shift form keeps RD_LATENCY=1 legal (no [-1:0] slice).
            pipe_q <= (pipe_q << 1) | RD_LATENCY'(strobe_i);
        end
    end

    assign wren_o = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/usb_cache_fill_ctrl.sv
// Burst sequencer: one fixed-length FX3 read burst per grant, pausing on FLAGA drop and
// writing every strobed word to consecutive cache addresses.
module usb_cache_fill_ctrl
    import usb_fx3_pkg::*;
#(
    parameter int         ADDR_W       = ADDR_W_DEF,
    parameter int         BURST_LEN    = BURST_LEN_DEF,
    parameter int         RD_LATENCY   = RD_LATENCY_DEF,
    parameter logic [1:0] RD_FIFO_ADDR = FX3_RD_SOCKET
) (
    input  logic                  wrclock,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cache_free,
    usb_cache_fill_ctrl_if.master bus,
    output logic [3:0]            usb_rd_state,
    output logic                  burst_done,
    output logic [15:0]           burst_cnt
);

    localparam logic [ADDR_W:0] LAST_STROBE = (ADDR_W+1)'(BURST_LEN - 1);
    localparam logic [2:0]      DRAIN_LAST  = 3'(RD_LATENCY - 1);

    rd_state_e         state_q;
    logic              slcs_n_q, sloe_n_q, slrd_n_q;
    logic [1:0]        fifoaddr_q;
    logic              flag_seen_q;
    logic [ADDR_W:0]   rd_cnt_q;
    logic [2:0]        drain_cnt_q;
    logic              burst_done_q;
    logic [15:0]       burst_cnt_q;
    logic [ADDR_W-1:0] wraddr_q;
    logic              wren_w;

    fx3_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_pipe (
        .wrclock  (wrclock),
        .rst_n    (rst_n),
        .strobe_i (~slrd_n_q),
        .wren_o   (wren_w)
    );

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wrclock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            slcs_n_q     <= 1'b1;
            sloe_n_q     <= 1'b1;
            slrd_n_q     <= 1'b1;
            fifoaddr_q   <= RD_FIFO_ADDR;
            flag_seen_q  <= 1'b0;
            rd_cnt_q     <= '0;
            drain_cnt_q  <= '0;
            burst_done_q <= 1'b0;
            burst_cnt_q  <= '0;
        end else begin
            fifoaddr_q   <= RD_FIFO_ADDR;
            burst_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    slcs_n_q    <= 1'b1;
                    sloe_n_q    <= 1'b1;
                    slrd_n_q    <= 1'b1;
                    flag_seen_q <= 1'b0;
                    if (enable && cache_free) state_q <= ST_WAIT_FLAG;
                end
                ST_WAIT_FLAG: begin
                    // FLAGA must be seen on two consecutive edges to filter glitches.
                    flag_seen_q <= bus.usb_flaga;
                    if (bus.usb_flaga && flag_seen_q) begin
                        slcs_n_q <= 1'b0;
                        state_q  <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    sloe_n_q <= 1'b0;
                    state_q  <= ST_OE_ON;
                end
                ST_OE_ON: begin
                    slrd_n_q <= 1'b0;
                    state_q  <= ST_STREAM;
                end
                ST_STREAM: begin
                    // The strobe issued this cycle always counts; the final strobe beats a FLAGA drop.
                    rd_cnt_q <= rd_cnt_q + (ADDR_W+1)'(1);
                    if (rd_cnt_q == LAST_STROBE) begin
                        slrd_n_q    <= 1'b1;
                        drain_cnt_q <= '0;
                        state_q     <= ST_DRAIN;
                    end else if (!bus.usb_flaga) begin
                        slrd_n_q <= 1'b1;
                        state_q  <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (bus.usb_flaga) begin
                        slrd_n_q <= 1'b0;
                        state_q  <= ST_STREAM;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        slcs_n_q     <= 1'b1;
                        sloe_n_q     <= 1'b1;
                        burst_done_q <= 1'b1;
                        burst_cnt_q  <= burst_cnt_q + 16'd1;
                        rd_cnt_q     <= '0;
                        state_q      <= ST_DONE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    slcs_n_q <= 1'b1;
                    sloe_n_q <= 1'b1;
                    slrd_n_q <= 1'b1;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    // Write address free-runs across bursts; only reset returns it to zero.
    always_ff @(posedge wrclock or negedge rst_n) begin
        if (!rst_n) begin
            wraddr_q <= '0;
        end else begin
            wraddr_q <= wraddr_q + ADDR_W'(wren_w);
        end
    end

    assign bus.usb_slcs_n      = slcs_n_q;
    assign bus.usb_sloe_n      = sloe_n_q;
    assign bus.usb_slrd_n      = slrd_n_q;
    assign bus.usb_fifoaddr    = fifoaddr_q;
    assign bus.cache_wren      = wren_w;
    assign bus.cache_wraddress = wraddr_q;
    assign usb_rd_state        = state_q;
    assign burst_done          = burst_done_q;
    assign burst_cnt           = burst_cnt_q;

endmodule
